// File: rtl/rosc_sample_buffer.sv
// rosc_sample_buffer: captures ROSC readings into a small FIFO, acknowledges the
// ROSC through a level handshake, and keeps running min/max/count statistics.
// When the FIFO is full the block withholds the acknowledge so the ROSC idles
// with its value held; samples are never dropped.
module rosc_sample_buffer #(
    parameter int Depth      = 8,
    parameter int AckTimeout = 255
) (
    input  logic                   Clk,
    input  logic                   ResetN,
    input  logic [15:0]            ROSCReading,
    input  logic [2:0]             ErrorCode,
    input  logic                   ROSCValReady,
    output logic                   CPUReadComplete,
    input  logic                   PopReq,
    output logic [15:0]            PopData,
    output logic [2:0]             PopErr,
    output logic                   PopValid,
    output logic [$clog2(Depth):0] Count,
    output logic                   Empty,
    output logic                   Full,
    output logic [15:0]            MinReading,
    output logic [15:0]            MaxReading,
    output logic [15:0]            SampleCount,
    output logic                   StickyErr,
    output logic                   AckTimeoutErr,
    input  logic                   ClearStats
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;
    localparam logic [7:0]      ACK_LIMIT = 8'(AckTimeout);
    localparam logic [CntW-1:0] DEPTH_CNT = CntW'(Depth);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        ACK     = 2'd2
    } state_t;

    state_t            state_r;
    logic [7:0]        ack_cnt_r;
    logic [18:0]       mem_r [Depth];
    logic [PtrW-1:0]   wr_ptr_r;
    logic [PtrW-1:0]   rd_ptr_r;

    logic              push_s;
    logic              pop_s;
    logic              timeout_s;
    logic [7:0]        ack_cnt_inc_s;
    logic [CntW-1:0]   count_nxt_s;
    logic [15:0]       min_base_s;
    logic [15:0]       max_base_s;
    logic [15:0]       sc_base_s;
    logic              sticky_base_s;
    logic              to_base_s;
    logic [15:0]       min_nxt_s;
    logic [15:0]       max_nxt_s;
    logic [15:0]       sc_nxt_s;
    logic              sticky_nxt_s;
    logic              to_nxt_s;

    // The push happens in the single CAPTURE cycle; Empty is the registered flag.
    assign push_s        = (state_r == CAPTURE);
    assign pop_s         = PopReq & ~Empty;
    assign ack_cnt_inc_s = ack_cnt_r + 8'd1;
    assign timeout_s     = (state_r == ACK) & ROSCValReady & (ack_cnt_inc_s == ACK_LIMIT);

    // Next FIFO occupancy from the push/pop pair of this cycle.
    always_comb begin
        count_nxt_s = Count;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = Count + CntW'(1);
            2'b01:   count_nxt_s = Count - CntW'(1);
            default: count_nxt_s = Count;
        endcase
    end

    // Statistics next-state: a coincident clear is applied first, then the new sample.
    always_comb begin
        if (ClearStats) begin
            min_base_s    = 16'hFFFF;
            max_base_s    = 16'h0000;
            sc_base_s     = 16'h0000;
            sticky_base_s = 1'b0;
            to_base_s     = 1'b0;
        end else begin
            min_base_s    = MinReading;
            max_base_s    = MaxReading;
            sc_base_s     = SampleCount;
            sticky_base_s = StickyErr;
            to_base_s     = AckTimeoutErr;
        end

        min_nxt_s    = min_base_s;
        max_nxt_s    = max_base_s;
        sc_nxt_s     = sc_base_s;
        sticky_nxt_s = sticky_base_s;
        to_nxt_s     = to_base_s;

        if (push_s) begin
            if (sc_base_s != 16'hFFFF) begin
                sc_nxt_s = sc_base_s + 16'd1;
            end else begin
                sc_nxt_s = sc_base_s;
            end
            if (ErrorCode == 3'd0) begin
                if (ROSCReading < min_base_s) begin
                    min_nxt_s = ROSCReading;
                end else begin
                    min_nxt_s = min_base_s;
                end
                if (ROSCReading > max_base_s) begin
                    max_nxt_s = ROSCReading;
                end else begin
                    max_nxt_s = max_base_s;
                end
            end else begin
                sticky_nxt_s = 1'b1;
            end
        end else begin
            sc_nxt_s = sc_base_s;
        end

        if (timeout_s) begin
            to_nxt_s = 1'b1;
        end else begin
            to_nxt_s = to_base_s;
        end
    end

    // Handshake FSM with registered acknowledge and ACK timeout counter.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_r         <= IDLE;
            CPUReadComplete <= 1'b0;
            ack_cnt_r       <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    CPUReadComplete <= 1'b0;
                    ack_cnt_r       <= 8'd0;
                    if (ROSCValReady && !Full) begin
                        state_r <= CAPTURE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CAPTURE: begin
                    state_r         <= ACK;
                    CPUReadComplete <= 1'b1;
                    ack_cnt_r       <= 8'd0;
                end
                ACK: begin
                    if (!ROSCValReady || timeout_s) begin
                        state_r         <= IDLE;
                        CPUReadComplete <= 1'b0;
                        ack_cnt_r       <= 8'd0;
                    end else begin
                        state_r         <= ACK;
                        CPUReadComplete <= 1'b1;
                        ack_cnt_r       <= ack_cnt_inc_s;
                    end
                end
                default: begin
                    state_r         <= IDLE;
                    CPUReadComplete <= 1'b0;
                    ack_cnt_r       <= 8'd0;
                end
            endcase
        end
    end

    // FIFO storage write; contents are discarded on reset through the pointers.
    always_ff @(posedge Clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {ErrorCode, ROSCReading};
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // FIFO pointers, occupancy and registered Empty/Full flags.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            Count    <= '0;
            Empty    <= 1'b1;
            Full     <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PtrW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PtrW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            Count <= count_nxt_s;
            Empty <= (count_nxt_s == {CntW{1'b0}});
            Full  <= (count_nxt_s == DEPTH_CNT);
        end
    end

    // Pop port: one-cycle latency, data held while no pop is in progress.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            PopValid <= 1'b0;
            PopData  <= 16'h0000;
            PopErr   <= 3'd0;
        end else begin
            if (pop_s) begin
                PopValid          <= 1'b1;
                {PopErr, PopData} <= mem_r[rd_ptr_r];
            end else begin
                PopValid <= 1'b0;
                PopData  <= PopData;
                PopErr   <= PopErr;
            end
        end
    end

    // Running statistics and sticky error flags.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            MinReading    <= 16'hFFFF;
            MaxReading    <= 16'h0000;
            SampleCount   <= 16'h0000;
            StickyErr     <= 1'b0;
            AckTimeoutErr <= 1'b0;
        end else begin
            MinReading    <= min_nxt_s;
            MaxReading    <= max_nxt_s;
            SampleCount   <= sc_nxt_s;
            StickyErr     <= sticky_nxt_s;
            AckTimeoutErr <= to_nxt_s;
        end
    end

endmodule
